upg_word_loader: RTL and testbench
==================================

# upg_word_loader

UART-programmer word loader that sequences the data-memory programming port. It consumes a byte stream from the UART receiver, parses a 16-bit word-count header, packs bytes little-endian into 32-bit words, and issues one write per word on the `upg_wen`/`upg_adr`/`upg_dat` lines of the data memory. It asserts `upg_done_o` when the image is complete, which hands the RAM back to the CPU. It sits between the UART receiver and the data memory's programming port.

## Interface

**Parameters**
- `ADDR_W`, default 14: word-address width of the data memory.
- `DEPTH`, default 16384: maximum number of words accepted.
- `TIMEOUT`, default 1000000: idle cycles allowed mid-image; 100 ms at 10 MHz.

**Ports**
- `upg_clk_i`  in  1  programming clock, 10 MHz.
- `upg_rstn_i`  in  1  reset, asynchronous, active-low.
- `byte_i`  in  8  received byte.
- `byte_valid_i`  in  1  `byte_i` is valid this cycle.
- `byte_ready_o`  out  1  loader accepts a byte this cycle.
- `restart_i`  in  1  one-cycle pulse: abort or rearm, return to IDLE.
- `upg_wen_o`  out  1  one-cycle RAM write strobe.
- `upg_adr_o`  out  `ADDR_W`  RAM word address.
- `upg_dat_o`  out  32  RAM write data.
- `upg_done_o`  out  1  image fully written.
- `err_o`  out  1  header invalid or timeout.

## Operation

- **Handshake:** a byte is accepted when `byte_valid_i & byte_ready_o` is high at a rising edge.
- **`byte_ready_o`:** equals 1 exactly in states LEN_LO, LEN_HI and DATA. It is decoded from the registered state only.
- **States:** IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
- **IDLE** is the reset state. It moves to LEN_LO unconditionally on the next edge.
- **LEN_LO:** accept a byte into `count[7:0]`, then go to LEN_HI. This state waits indefinitely; no timeout applies.
- **LEN_HI:** accept a byte into `count[15:8]`, then check the count.
  - If `count == 0` or `count > DEPTH`, go to ERR.
  - Otherwise clear the byte index and word address, then go to DATA.
- **DATA:** accepted bytes fill `word[8*idx +: 8]`, with idx counting 0..3.
  - On the byte with idx = 3, go to WRITE.
- **WRITE:** lasts exactly one cycle.
  - `upg_wen_o` = 1, `upg_adr_o` = current address, `upg_dat_o` = the packed word.
  - If address == count-1, go to DONE.
  - Otherwise increment the address, clear idx, and go to DATA.
- **DONE:** `upg_done_o` = 1. The state holds until `restart_i`.
- **ERR:** `err_o` = 1. The state holds until `restart_i`.
- **Timeout:** the counter is active only in LEN_HI and DATA.
  - It clears on every accepted byte and on entry to LEN_HI.
  - When it reaches `TIMEOUT-1` with no byte accepted, go to ERR.
- **`restart_i`** from any state goes to IDLE and clears count, address, idx and the timeout counter.
- **Priority** at a single edge: reset > `restart_i` > byte accept > timeout expiry. A byte arriving on the expiry cycle is accepted and no error is raised.
- **Width rules:**
  - count is 16 bits; `DEPTH` is compared at 17 bits.
  - The address never exceeds count-1 and never wraps.

## Timing

- **Reset values:** `byte_ready_o` 0, `upg_wen_o` 0, `upg_adr_o` 0, `upg_dat_o` 0, `upg_done_o` 0, `err_o` 0.
- **First ready:** `byte_ready_o` first rises one cycle after `upg_rstn_i` deasserts.
- **Outputs:** all outputs are registered or decoded from registered state. No combinational path runs from `byte_valid_i` to any output.
- **Write latency:** `upg_wen_o` is high in the cycle immediately after the 4th byte of a word is accepted.
- **Backpressure:** `byte_ready_o` is 0 during WRITE, so sustained throughput is one word per 5 cycles.
- **Done latency:** `upg_done_o` rises one cycle after the final WRITE cycle. It falls one cycle after `restart_i`.
- **Stability:** `upg_adr_o` and `upg_dat_o` hold their last written values outside WRITE.

## Structure

- **Package `upg_pkg`:**
  - state enum `upg_state_t`, 3 bits;
  - `UPG_HDR_BYTES` = 2;
  - `UPG_BYTES_PER_WORD` = 4.
- **Sub-module `upg_timeout_counter`:** ports clk, rstn, `clr`, `en`, `expired_o`; parameter `TIMEOUT`. It is instantiated once.
- **FSM:** kept in the top module, with a single `always_ff` for state and datapath registers.

## Test plan

- **Normal load:** header 0x02,0x00, then bytes 0x11 0x22 0x33 0x44 0xAA 0xBB 0xCC 0xDD.
  - WRITE (adr 0, 0x44332211), then WRITE (adr 1, 0xDDCCBBAA).
  - `upg_done_o` = 1 one cycle later.
- **Invalid header:** header 0x00,0x00 gives `err_o` = 1 and no `upg_wen_o`. Header 0x01,0x40 (16385 words) gives the same.
- **Timeout:** with `TIMEOUT` = 16, send the header for 1 word plus 2 data bytes, then stall.
  - `err_o` rises 16 cycles after the last accept; `upg_wen_o` never pulses.
- **Accept on expiry:** a byte presented on the expiry cycle is accepted, and the load completes without error.
- **Backpressure:** hold `byte_valid_i` high continuously.
  - `byte_ready_o` is low exactly in each WRITE cycle, and no byte is lost or duplicated.
- **Restart mid-image:** pulse `restart_i` after 3 of 8 data bytes.
  - State returns to IDLE, then LEN_LO.
  - A fresh 1-word image then writes to address 0 and asserts done.
- **Reset mid-image:** assert `upg_rstn_i` mid-image.
  - All outputs go to 0 immediately (asynchronously).

Source files
------------

// File: rtl/upg_pkg.sv
// Shared types and constants for the UART-programmer word loader.
//   upg_state_t        : loader FSM state encoding (3 bits)
//   UPG_HDR_BYTES      : bytes in the little-endian word-count header
//   UPG_BYTES_PER_WORD : bytes packed into each 32-bit RAM word
package upg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } upg_state_t;

    localparam int UPG_HDR_BYTES      = 2;
    localparam int UPG_BYTES_PER_WORD = 4;

endpackage

// File: rtl/upg_timeout_counter.sv
// Idle-cycle watchdog for the word loader.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : synchronous clear (highest priority after reset)
//   en        : count enable
//   expired_o : counter has reached TIMEOUT-1; it saturates there
module upg_timeout_counter #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign expired_o = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired_o) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/upg_word_loader.sv
// UART-programmer word loader. Parses a 16-bit little-endian word-count
// header from the byte stream, packs data bytes little-endian into 32-bit
// words and issues one RAM write per word; flags done or error.
//   upg_clk_i, upg_rstn_i : clock, asynchronous active-low reset
//   byte_i/byte_valid_i/byte_ready_o : byte stream handshake
//   restart_i   : one-cycle pulse, abort/rearm back to IDLE
//   upg_wen_o/upg_adr_o/upg_dat_o : data-memory programming port
//   upg_done_o  : image fully written
//   err_o       : bad header or mid-image timeout
module upg_word_loader
    import upg_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DEPTH   = 16384,
    parameter int TIMEOUT = 1000000
) (
    input  logic              upg_clk_i,
    input  logic              upg_rstn_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              restart_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);

    localparam int          CNT_W   = 8 * UPG_HDR_BYTES;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    upg_state_t        state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        idx;
    logic [31:0]       word;

    logic              accept;
    logic              expired;
    logic              tmo_en;
    logic              hdr_bad;
    logic              last_byte;
    logic              last_word;
    logic [CNT_W-1:0]  hdr_cnt;

    assign accept    = byte_valid_i & byte_ready_o;
    assign hdr_cnt   = {byte_i, count[7:0]};
    // 17-bit compare so DEPTH = 65536 would still be representable
    assign hdr_bad   = (hdr_cnt == '0) || ({1'b0, hdr_cnt} > DEPTH_W);
    assign last_byte = (idx == 2'(UPG_BYTES_PER_WORD - 1));
    assign last_word = (17'(addr) == ({1'b0, count} - 17'd1));
    assign tmo_en    = (state == ST_LEN_HI) || (state == ST_DATA);

    // Cleared outside its active states, so it starts from zero on entry
    upg_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (upg_clk_i),
        .rstn      (upg_rstn_i),
        .clr       (accept | restart_i | ~tmo_en),
        .en        (tmo_en),
        .expired_o (expired)
    );

    // State and datapath registers
    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            state     <= ST_IDLE;
            count     <= '0;
            addr      <= '0;
            idx       <= '0;
            word      <= '0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
        end else begin
            state <= state_nxt;
            if (restart_i) begin
                count <= '0;
                addr  <= '0;
                idx   <= '0;
            end else begin
                case (state)
                    ST_LEN_LO: if (accept) count[7:0] <= byte_i;
                    ST_LEN_HI: begin
                        if (accept) begin
                            count[15:8] <= byte_i;
                            addr        <= '0;
                            idx         <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            word[{idx, 3'b000} +: 8] <= byte_i;
                            idx                      <= idx + 2'd1;
                            // Output regs load only here, so they hold between writes
                            if (last_byte) begin
                                upg_adr_o <= addr;
                                upg_dat_o <= {byte_i, word[23:0]};
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (!last_word) begin
                            addr <= addr + ADDR_W'(1);
                            idx  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next state; an accepted byte outranks timeout expiry
    always_comb begin
        state_nxt = state;
        if (restart_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_LEN_LO;
                ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (accept)       state_nxt = hdr_bad ? ST_ERR : ST_DATA;
                    else if (expired) state_nxt = ST_ERR;
                end
                ST_DATA: begin
                    if (accept) begin
                        if (last_byte) state_nxt = ST_WRITE;
                    end else if (expired) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_WRITE:  state_nxt = last_word ? ST_DONE : ST_DATA;
                ST_DONE:   state_nxt = ST_DONE;
                ST_ERR:    state_nxt = ST_ERR;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        byte_ready_o = 1'b0;
        upg_wen_o    = 1'b0;
        upg_done_o   = 1'b0;
        err_o        = 1'b0;
        case (state)
            ST_LEN_LO, ST_LEN_HI, ST_DATA: byte_ready_o = 1'b1;
            ST_WRITE:                      upg_wen_o    = 1'b1;
            ST_DONE:                       upg_done_o   = 1'b1;
            ST_ERR:                        err_o        = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_upg_word_loader.sv
// Directed self-checking bench for upg_word_loader (TIMEOUT = 16).
module tb_upg_word_loader;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rstn;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              restart;
    logic              wen;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
    logic              done;
    logic              err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_wr   = 0;
    int rdy_bad = 0;
    logic [ADDR_W-1:0] wr_adr [16];
    logic [31:0]       wr_dat [16];

    upg_word_loader #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (16384),
        .TIMEOUT (16)
    ) dut (
        .upg_clk_i    (clk),
        .upg_rstn_i   (rstn),
        .byte_i       (byte_in),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .restart_i    (restart),
        .upg_wen_o    (wen),
        .upg_adr_o    (adr),
        .upg_dat_o    (dat),
        .upg_done_o   (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write capture; ready must never be high in a write cycle
    always @(negedge clk) begin
        if (wen) begin
            wr_adr[n_wr % 16] <= adr;
            wr_dat[n_wr % 16] <= dat;
            n_wr <= n_wr + 1;
            if (byte_ready) rdy_bad <= rdy_bad + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] b);
        int g = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("send_bound", 32'(byte_ready), 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    initial begin
        int n0;
        int k;
        int t0;
        int t1;
        rstn = 1'b0; restart = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_wen",   32'(wen),        32'd0);
        chk("rst_adr",   32'(adr),        32'd0);
        chk("rst_dat",   dat,             32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_err",   32'(err),        32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("first_ready", 32'(byte_ready), 32'd1);

        // Normal 2-word load
        n0 = n_wr;
        send(8'h02); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("w0_wen", 32'(wen), 32'd1);
        chk("w0_adr", 32'(adr), 32'd0);
        chk("w0_dat", dat, 32'h44332211);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        chk("w1_wen",  32'(wen),  32'd1);
        chk("w1_adr",  32'(adr),  32'd1);
        chk("w1_dat",  dat, 32'hDDCCBBAA);
        chk("w1_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("done_rise",   32'(done), 32'd1);
        chk("done_wen",    32'(wen),  32'd0);
        chk("hold_adr",    32'(adr),  32'd1);
        chk("hold_dat",    dat, 32'hDDCCBBAA);
        chk("norm_err",    32'(err),  32'd0);
        chk("norm_nwr",    32'(n_wr - n0), 32'd2);

        // Restart from DONE
        pulse_restart();
        chk("done_fall",  32'(done),       32'd0);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        chk("lenlo_ready", 32'(byte_ready), 32'd1);

        // Invalid headers: zero, DEPTH+1; DEPTH itself is accepted
        n0 = n_wr;
        send(8'h00); send(8'h00);
        chk("hdr0_err", 32'(err), 32'd1);
        repeat (3) @(negedge clk);
        chk("hdr0_hold", 32'(err), 32'd1);
        chk("hdr0_rdy",  32'(byte_ready), 32'd0);
        pulse_restart();
        send(8'h01); send(8'h40);
        chk("hdrbig_err", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        chk("hdr_nowr", 32'(n_wr - n0), 32'd0);
        pulse_restart();
        send(8'h00); send(8'h40);
        chk("hdrmax_err", 32'(err),        32'd0);
        chk("hdrmax_rdy", 32'(byte_ready), 32'd1);

        // Timeout: err 16 edges after the last accept
        pulse_restart();
        n0 = n_wr;
        send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        k = 0;
        while (!err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_cycles", 32'(k), 32'd16);
        @(negedge clk);
        chk("tmo_nowr", 32'(n_wr - n0), 32'd0);

        // Byte offered on the expiry cycle wins
        pulse_restart();
        send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        repeat (15) @(negedge clk);
        chk("exp_pre_err", 32'(err), 32'd0);
        send(8'h33); send(8'h44);
        chk("exp_wen", 32'(wen), 32'd1);
        chk("exp_adr", 32'(adr), 32'd0);
        chk("exp_dat", dat, 32'h44332211);
        @(negedge clk);
        chk("exp_done", 32'(done), 32'd1);
        chk("exp_err",  32'(err),  32'd0);

        // Backpressure with valid held high: 3 words, 5 cycles per word
        pulse_restart();
        n0 = n_wr;
        send(8'h03); send(8'h00);
        t0 = cyc;
        for (int i = 1; i <= 12; i++) send(8'(i));
        t1 = cyc;
        chk("bp_cycles", 32'(t1 - t0), 32'd14);
        @(negedge clk);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_nwr",  32'(n_wr - n0), 32'd3);
        chk("bp_adr0", 32'(wr_adr[(n0 + 0) % 16]), 32'd0);
        chk("bp_adr1", 32'(wr_adr[(n0 + 1) % 16]), 32'd1);
        chk("bp_adr2", 32'(wr_adr[(n0 + 2) % 16]), 32'd2);
        chk("bp_dat0", wr_dat[(n0 + 0) % 16], 32'h04030201);
        chk("bp_dat1", wr_dat[(n0 + 1) % 16], 32'h08070605);
        chk("bp_dat2", wr_dat[(n0 + 2) % 16], 32'h0C0B0A09);
        chk("bp_rdy_in_write", 32'(rdy_bad), 32'd0);

        // Restart mid-image, then a fresh 1-word image
        pulse_restart();
        n0 = n_wr;
        send(8'h02); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
        pulse_restart();
        chk("mid_idle_rdy", 32'(byte_ready), 32'd0);
        chk("mid_idle_wen", 32'(wen),        32'd0);
        @(negedge clk);
        chk("mid_lenlo_rdy", 32'(byte_ready), 32'd1);
        send(8'h01); send(8'h00); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        chk("mid_wen", 32'(wen), 32'd1);
        chk("mid_adr", 32'(adr), 32'd0);
        chk("mid_dat", dat, 32'hD4C3B2A1);
        @(negedge clk);
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_nwr",  32'(n_wr - n0), 32'd1);

        // Asynchronous reset during a write cycle
        pulse_restart();
        send(8'h02); send(8'h00); send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        chk("ar_pre_dat", dat, 32'h88776655);
        #2 rstn = 1'b0;
        #1;
        chk("ar_ready", 32'(byte_ready), 32'd0);
        chk("ar_wen",   32'(wen),        32'd0);
        chk("ar_adr",   32'(adr),        32'd0);
        chk("ar_dat",   dat,             32'd0);
        chk("ar_done",  32'(done),       32'd0);
        chk("ar_err",   32'(err),        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
